sram_sp_arbiter: RTL and testbench

- Controller that owns one single-port SRAM macro (256 x 72, shared RW0 port, 1-cycle registered-address read) and shares it between one read requester and one write requester.
- After reset it sequences a full-array initialisation sweep. It then arbitrates per cycle, with write priority and bounded read starvation.
- Sits between pipeline-side request logic and the SRAM macro wrapper.

---
 rtl/sram_sp_arbiter_pkg.sv | 22 ++
 rtl/sram_sp_grant.sv | 28 ++
 rtl/sram_sp_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_sp_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sp_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_sp_arbiter_pkg                                          |
// | Description : Shared types and default constants for the single-port      |
// |               SRAM arbiter slice.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sram_sp_arbiter_pkg;

    localparam int c_ADDR_W       = 8;
    localparam int c_DATA_W       = 72;
    localparam int c_DEPTH        = 256;
    localparam int c_STARVE_LIMIT = 4;

    // Controller phase: initialisation sweep, then normal arbitration
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : sram_sp_arbiter_pkg
`default_nettype wire

// File: rtl/sram_sp_grant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_sp_grant                                                |
// | Description : Combinational write-priority grant with bounded read        |
// |               starvation. Grants are mutually exclusive by construction.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_sp_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       r_req_valid,
    input  logic       w_req_valid,
    input  logic [3:0] starve_cnt,
    output logic       grant_r,
    output logic       grant_w
);

    logic w_force_read;

    // Read wins a conflict only once it has lost STARVE_LIMIT times in a row
    always_comb begin
        w_force_read = (starve_cnt >= 4'(STARVE_LIMIT));
        grant_r      = r_req_valid & (~w_req_valid | w_force_read);
        grant_w      = w_req_valid & ~(r_req_valid & w_force_read);
    end

endmodule : sram_sp_grant
`default_nettype wire

// File: rtl/sram_sp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_sp_arbiter                                              |
// | Description : Owns a single-port SRAM macro: runs a full-array init sweep |
// |               after reset, then arbitrates one reader and one writer.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_sp_arbiter
    import sram_sp_arbiter_pkg::*;
#(
    parameter int                ADDR_W       = c_ADDR_W,
    parameter int                DATA_W       = c_DATA_W,
    parameter int                DEPTH        = c_DEPTH,
    parameter int                STARVE_LIMIT = c_STARVE_LIMIT,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    // One extra bit so the terminal count is never confused with a wrap to 0
    localparam logic [ADDR_W:0] c_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_init_cnt;
    logic [3:0]        r_starve_cnt;
    logic              r_resp_pend;
    logic              r_init_done;
    logic              w_run;
    logic              w_grant_r;
    logic              w_grant_w;

    assign w_run = (r_state == ST_RUN);

    // Requests are masked outside RUN so no grant can appear during the sweep
    sram_sp_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .r_req_valid (r_req_valid & w_run),
        .w_req_valid (w_req_valid & w_run),
        .starve_cnt  (r_starve_cnt),
        .grant_r     (w_grant_r),
        .grant_w     (w_grant_w)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and SRAM port drive; everything is quiet while reset is high
    always_comb begin
        w_state_nxt = r_state;
        sram_en     = 1'b0;
        sram_wmode  = 1'b0;
        sram_addr   = r_req_addr;
        sram_wdata  = w_req_data;
        r_req_ready = 1'b0;
        w_req_ready = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_INIT: begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = r_init_cnt[ADDR_W-1:0];
                    sram_wdata = INIT_VALUE;
                    if (r_init_cnt == c_LAST) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_req_ready = w_grant_r;
                    w_req_ready = w_grant_w;
                    sram_en     = w_grant_r | w_grant_w;
                    sram_wmode  = w_grant_w;
                    sram_addr   = w_grant_w ? w_req_addr : r_req_addr;
                end
                default: begin
                    w_state_nxt = ST_INIT;
                end
            endcase
        end
    end

    // Sweep counter, starvation counter, init flag and read-response pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            r_init_cnt   <= '0;
            r_starve_cnt <= '0;
            r_resp_pend  <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            r_resp_pend <= w_grant_r;
            r_init_done <= (w_state_nxt == ST_RUN);
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            if (!r_req_valid || w_grant_r) begin
                r_starve_cnt <= '0;
            end else if (w_grant_w && (r_starve_cnt < 4'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    // A response whose cycle coincides with reset is dropped
    assign r_resp_valid = r_resp_pend & ~reset;
    assign r_resp_data  = sram_rdata;
    assign init_done    = r_init_done;

endmodule : sram_sp_arbiter
`default_nettype wire

// File: tb/tb_sram_sp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_sp_arbiter                                           |
// | Description : Scoreboard bench for sram_sp_arbiter with a behavioural     |
// |               SRAM macro model.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_sp_arbiter;

    localparam logic [71:0] c_WDATA = 72'h12_3456_789A_BCDE_F011;
    localparam logic [71:0] c_JUNK  = 72'hDE_ADBE_EFDE_ADBE_EF55;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r_req_valid = 1'b0;
    logic        r_req_ready;
    logic [7:0]  r_req_addr = '0;
    logic        r_resp_valid;
    logic [71:0] r_resp_data;
    logic        w_req_valid = 1'b0;
    logic        w_req_ready;
    logic [7:0]  w_req_addr = '0;
    logic [71:0] w_req_data = '0;
    logic        init_done;
    logic        sram_en;
    logic        sram_wmode;
    logic [7:0]  sram_addr;
    logic [71:0] sram_wdata;
    logic [71:0] sram_rdata = '0;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_resp  = 0;
    logic [71:0] exp_q[$];
    logic        prev_rready = 1'b0;
    logic [71:0] mem [256];

    always #5 clock = ~clock;

    sram_sp_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_addr   (w_req_addr),
        .w_req_data   (w_req_data),
        .init_done    (init_done),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // Behavioural single-port macro, pre-filled with junk so init is observable
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = c_JUNK;
    end
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) mem[sram_addr] <= sram_wdata;
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic chk(input bit ok, input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Response monitor: pops the scoreboard whenever a response is due or shown
    always @(negedge clock) begin
        if (prev_rready && reset) begin
            chk(r_resp_valid == 1'b0, "resp_drop", 96'(r_resp_valid), 96'd0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (prev_rready || r_resp_valid) begin
            chk(r_resp_valid == prev_rready, "resp_timing", 96'(r_resp_valid), 96'(prev_rready));
            if (r_resp_valid) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "resp_unexpected", 96'(r_resp_data), 96'd0);
                end else begin
                    logic [71:0] e;
                    e = exp_q.pop_front();
                    chk(r_resp_data == e, "resp_data", 96'(r_resp_data), 96'(e));
                end
            end
        end
        prev_rready = r_req_ready;
    end

    // Checks n sweep cycles with both requesters pushing (no ready allowed)
    task automatic sweep_check(input int n, input bit expect_done);
        r_req_valid = 1'b1; r_req_addr = 8'h3A;
        w_req_valid = 1'b1; w_req_addr = 8'hFF; w_req_data = '1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk({sram_en, sram_wmode, sram_addr, sram_wdata, r_req_ready, w_req_ready, init_done}
                == {1'b1, 1'b1, 8'(i), 72'h0, 3'b000}, "init_sweep",
                96'({sram_en, sram_wmode, sram_addr, sram_wdata, r_req_ready, w_req_ready, init_done}),
                96'({1'b1, 1'b1, 8'(i), 72'h0, 3'b000}));
        end
        r_req_valid = 1'b0;
        w_req_valid = 1'b0;
        if (expect_done) begin
            @(negedge clock);
            chk(init_done == 1'b1, "init_done_rise", 96'(init_done), 96'd1);
            chk(sram_en == 1'b0, "idle_after_init", 96'(sram_en), 96'd0);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [71:0] d);
        bit got = 1'b0;
        w_req_valid = 1'b1; w_req_addr = a; w_req_data = d;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = w_req_ready;
        end
        if (!got) chk(1'b0, "write_timeout", 96'd0, 96'd1);
        @(posedge clock); #1;
        w_req_valid = 1'b0;
    endtask

    // Issues a read and queues the expected data when it is accepted
    task automatic do_read(input logic [7:0] a, input logic [71:0] e, input bit hold_after);
        bit got = 1'b0;
        r_req_valid = 1'b1; r_req_addr = a;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = r_req_ready;
            if (got) exp_q.push_back(e);
        end
        if (!got) chk(1'b0, "read_timeout", 96'd0, 96'd1);
        if (!hold_after) begin
            @(posedge clock); #1;
            r_req_valid = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk({sram_en, r_req_ready, w_req_ready, init_done, r_resp_valid} == 5'b0, "reset_state",
            96'({sram_en, r_req_ready, w_req_ready, init_done, r_resp_valid}), 96'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Full sweep after reset
        sweep_check(256, 1'b1);

        // Read of an initialised entry
        @(posedge clock); #1;
        do_read(8'h3A, 72'h0, 1'b0);
        repeat (2) @(posedge clock);
        #1;

        // Write then read the same address on the following cycle
        do_write(8'h80, c_WDATA);
        do_read(8'h80, c_WDATA, 1'b0);
        repeat (2) @(posedge clock);
        #1;

        // Continuous conflict: W,W,W,W,R repeating
        begin
            int r0;
            r0 = n_resp;
            r_req_valid = 1'b1; r_req_addr = 8'h80;
            w_req_valid = 1'b1; w_req_addr = 8'h11; w_req_data = 72'h55;
            for (int i = 0; i < 20; i++) begin
                bit er;
                @(negedge clock);
                er = ((i % 5) == 4);
                chk({r_req_ready, w_req_ready} == {er, ~er}, "conflict_grant",
                    96'({r_req_ready, w_req_ready}), 96'({er, ~er}));
                if (r_req_ready) exp_q.push_back(c_WDATA);
            end
            @(posedge clock); #1;
            r_req_valid = 1'b0; w_req_valid = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            chk(n_resp - r0 == 4, "conflict_resp_count", 96'(n_resp - r0), 96'd4);
            do_read(8'h11, 72'h55, 1'b0);
            repeat (2) @(posedge clock);
            #1;
        end

        // Reset at init cycle 100, then full restart
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sweep_check(100, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk({sram_en, init_done} == 2'b00, "reset_mid_init", 96'({sram_en, init_done}), 96'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        sweep_check(256, 1'b1);

        // Reset the cycle after a read grant drops the response
        @(posedge clock); #1;
        do_read(8'h3A, 72'h0, 1'b1);
        @(posedge clock); #1;
        r_req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sweep_check(256, 1'b1);

        repeat (3) @(posedge clock);
        chk(exp_q.size() == 0, "scoreboard_empty", 96'(exp_q.size()), 96'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sram_sp_arbiter
`default_nettype wire
